// File: rtl/rect_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rect_commit_ctrl
// Takes rectangle coordinate updates from the SoC and sequences them into the
// VGA renderer. A request is captured on each DataValid rising edge, ordered
// (lo/hi per axis) and range-checked. It is committed to disp_* only on a
// frame boundary, so the renderer never draws a torn rectangle.
//
// Optional feature macro: COORD_CLAMP_EN
//   defined   : out-of-range coordinates clamp to the last visible pixel/line
//   undefined : out-of-range requests are rejected and range_err is set
//
// Ports
//   HCLK, HRESETn               clock, async active-low reset
//   x1, x2, y1, y2              raw (unordered) coordinates from the SoC
//   DataValid                   request level; a request is its rising edge
//   frame_start                 1-cycle pulse at start of vertical blanking
//   err_clr                     synchronous clear of overrun / range_err
//   disp_x1..disp_y2            committed coordinates (x1<=x2, y1<=y2)
//   req_ack                     pulse: request accepted into staging
//   commit                      pulse: disp_* updated this cycle
//   busy                        high while the FSM is not idle
//   overrun                     sticky: a request was dropped or replaced
//   range_err                   sticky: a request was rejected out of range
//   frame_count                 free-running frame_start counter (wraps)
// ---------------------------------------------------------------------------
module rect_commit_ctrl #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] y2,
    input  logic               DataValid,
    input  logic               frame_start,
    input  logic               err_clr,
    output logic [COORD_W-1:0] disp_x1,
    output logic [COORD_W-1:0] disp_x2,
    output logic [COORD_W-1:0] disp_y1,
    output logic [COORD_W-1:0] disp_y2,
    output logic               req_ack,
    output logic               commit,
    output logic               busy,
    output logic               overrun,
    output logic               range_err,
    output logic [15:0]        frame_count
);

    localparam int unsigned FC_W = 16;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NORM   = 2'd1,
        PEND   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t state, state_d;

    logic               dv_q;
    logic               req_c;

    logic [COORD_W-1:0] stg_x1, stg_x2, stg_y1, stg_y2;
    logic [COORD_W-1:0] stg_x1_d, stg_x2_d, stg_y1_d, stg_y2_d;
    logic [COORD_W-1:0] disp_x1_d, disp_x2_d, disp_y1_d, disp_y2_d;
    logic               req_ack_d, commit_d, busy_d;
    logic               overrun_d, range_err_d;
    logic               ovr_set_c, rng_set_c;
    logic [FC_W-1:0]    frame_count_d;

    // Ordered (and possibly clamped) view of the raw staging registers
    logic [COORD_W-1:0] x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic [COORD_W-1:0] nx_lo_c, nx_hi_c, ny_lo_c, ny_hi_c;

    // Request = rising edge of DataValid; held-high gives a single request
    assign req_c = DataValid & ~dv_q;

    // Per-axis min/max of the raw staged coordinates
    always_comb begin
        x_lo_c = (stg_x1 <= stg_x2) ? stg_x1 : stg_x2;
        x_hi_c = (stg_x1 <= stg_x2) ? stg_x2 : stg_x1;
        y_lo_c = (stg_y1 <= stg_y2) ? stg_y1 : stg_y2;
        y_hi_c = (stg_y1 <= stg_y2) ? stg_y2 : stg_y1;
    end

`ifdef COORD_CLAMP_EN
    // Clamping after ordering keeps lo <= hi
    always_comb begin
        nx_lo_c = (x_lo_c > X_MAX) ? X_MAX : x_lo_c;
        nx_hi_c = (x_hi_c > X_MAX) ? X_MAX : x_hi_c;
        ny_lo_c = (y_lo_c > Y_MAX) ? Y_MAX : y_lo_c;
        ny_hi_c = (y_hi_c > Y_MAX) ? Y_MAX : y_hi_c;
    end
`else
    logic oob_c;

    // hi is the max per axis, so checking it covers both coordinates
    always_comb begin
        nx_lo_c = x_lo_c;
        nx_hi_c = x_hi_c;
        ny_lo_c = y_lo_c;
        ny_hi_c = y_hi_c;
        oob_c   = (x_hi_c > X_MAX) || (y_hi_c > Y_MAX);
    end
`endif

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state;
        stg_x1_d  = stg_x1;
        stg_x2_d  = stg_x2;
        stg_y1_d  = stg_y1;
        stg_y2_d  = stg_y2;
        disp_x1_d = disp_x1;
        disp_x2_d = disp_x2;
        disp_y1_d = disp_y1;
        disp_y2_d = disp_y2;
        req_ack_d = 1'b0;
        commit_d  = 1'b0;
        ovr_set_c = 1'b0;
        rng_set_c = 1'b0;

        case (state)
            IDLE: begin
                if (req_c) begin
                    stg_x1_d  = x1;
                    stg_x2_d  = x2;
                    stg_y1_d  = y1;
                    stg_y2_d  = y2;
                    req_ack_d = 1'b1;
                    state_d   = NORM;
                end
            end
            NORM: begin
                if (req_c) begin
                    ovr_set_c = 1'b1;
                end
`ifdef COORD_CLAMP_EN
                stg_x1_d = nx_lo_c;
                stg_x2_d = nx_hi_c;
                stg_y1_d = ny_lo_c;
                stg_y2_d = ny_hi_c;
                state_d  = PEND;
`else
                if (oob_c) begin
                    rng_set_c = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stg_x1_d = nx_lo_c;
                    stg_x2_d = nx_hi_c;
                    stg_y1_d = ny_lo_c;
                    stg_y2_d = ny_hi_c;
                    state_d  = PEND;
                end
`endif
            end
            PEND: begin
                if (frame_start) begin
                    // Frame boundary wins over a coincident request
                    disp_x1_d = stg_x1;
                    disp_x2_d = stg_x2;
                    disp_y1_d = stg_y1;
                    disp_y2_d = stg_y2;
                    commit_d  = 1'b1;
                    state_d   = COMMIT;
                    if (req_c) begin
                        ovr_set_c = 1'b1;
                    end
                end else if (req_c) begin
                    // Latest request replaces the staged one
                    stg_x1_d  = x1;
                    stg_x2_d  = x2;
                    stg_y1_d  = y1;
                    stg_y2_d  = y2;
                    req_ack_d = 1'b1;
                    ovr_set_c = 1'b1;
                    state_d   = NORM;
                end
            end
            COMMIT: begin
                if (req_c) begin
                    ovr_set_c = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle as err_clr wins
    always_comb begin
        overrun_d     = ovr_set_c | (overrun & ~err_clr);
        range_err_d   = rng_set_c | (range_err & ~err_clr);
        busy_d        = (state_d != IDLE);
        frame_count_d = frame_start ? (frame_count + FC_W'(1)) : frame_count;
    end

    // Datapath and output registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dv_q        <= 1'b0;
            stg_x1      <= '0;
            stg_x2      <= '0;
            stg_y1      <= '0;
            stg_y2      <= '0;
            disp_x1     <= '0;
            disp_x2     <= '0;
            disp_y1     <= '0;
            disp_y2     <= '0;
            req_ack     <= 1'b0;
            commit      <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            range_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            dv_q        <= DataValid;
            stg_x1      <= stg_x1_d;
            stg_x2      <= stg_x2_d;
            stg_y1      <= stg_y1_d;
            stg_y2      <= stg_y2_d;
            disp_x1     <= disp_x1_d;
            disp_x2     <= disp_x2_d;
            disp_y1     <= disp_y1_d;
            disp_y2     <= disp_y2_d;
            req_ack     <= req_ack_d;
            commit      <= commit_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
            range_err   <= range_err_d;
            frame_count <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_rect_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rect_commit_ctrl
// Directed bench for rect_commit_ctrl: reset, ordering, latest-wins overrun,
// range handling (both COORD_CLAMP_EN builds), request/frame collision,
// frame counter wrap and reset while pending.
// ---------------------------------------------------------------------------
module tb_rect_commit_ctrl;

    localparam int unsigned COORD_W = 10;

    logic               HCLK;
    logic               HRESETn;
    logic [COORD_W-1:0] x1, x2, y1, y2;
    logic               DataValid;
    logic               frame_start;
    logic               err_clr;
    logic [COORD_W-1:0] disp_x1, disp_x2, disp_y1, disp_y2;
    logic               req_ack, commit, busy, overrun, range_err;
    logic [15:0]        frame_count;

    int n_cmp;
    int n_err;

    rect_commit_ctrl #(
        .COORD_W (COORD_W),
        .H_ACTIVE(640),
        .V_ACTIVE(480)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .x1         (x1),
        .x2         (x2),
        .y1         (y1),
        .y2         (y2),
        .DataValid  (DataValid),
        .frame_start(frame_start),
        .err_clr    (err_clr),
        .disp_x1    (disp_x1),
        .disp_x2    (disp_x2),
        .disp_y1    (disp_y1),
        .disp_y2    (disp_y2),
        .req_ack    (req_ack),
        .commit     (commit),
        .busy       (busy),
        .overrun    (overrun),
        .range_err  (range_err),
        .frame_count(frame_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input int ex1, input int ex2,
                            input int ey1, input int ey2);
        chk({tag, ".x1"}, 32'(disp_x1), 32'(ex1));
        chk({tag, ".x2"}, 32'(disp_x2), 32'(ex2));
        chk({tag, ".y1"}, 32'(disp_y1), 32'(ey1));
        chk({tag, ".y2"}, 32'(disp_y2), 32'(ey2));
    endtask

    task automatic set_coords(input int a, input int b, input int c, input int d);
        x1 = COORD_W'(a);
        x2 = COORD_W'(b);
        y1 = COORD_W'(c);
        y2 = COORD_W'(d);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        HRESETn     = 1'b1;
        DataValid   = 1'b0;
        frame_start = 1'b0;
        err_clr     = 1'b0;
        set_coords(0, 0, 0, 0);

        // Reset
        #2 HRESETn = 1'b0;
        #1;
        chk_disp("rst_disp", 0, 0, 0, 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_commit", 32'(commit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_range_err", 32'(range_err), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_commit", 32'(commit), 0);

        // Basic ordering: (100,20,50,300) -> (20,100,50,300)
        set_coords(100, 20, 50, 300);
        DataValid = 1'b1;
        tick();
        chk("t1_req_ack", 32'(req_ack), 1);
        chk("t1_busy", 32'(busy), 1);
        DataValid = 1'b0;
        tick();
        chk("t1_req_ack_pulse", 32'(req_ack), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_wait_commit", 32'(commit), 0);
            chk_disp("t1_wait_disp", 0, 0, 0, 0);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t1_commit", 32'(commit), 1);
        chk_disp("t1_disp", 20, 100, 50, 300);
        chk("t1_frame_count", 32'(frame_count), 1);
        tick();
        chk("t1_commit_pulse", 32'(commit), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_overrun", 32'(overrun), 0);

        // Two requests while pending: latest wins, overrun set
        set_coords(10, 20, 10, 20);
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        tick();
        tick();
        set_coords(30, 40, 30, 40);
        DataValid = 1'b1;
        tick();
        chk("t2_req_ack", 32'(req_ack), 1);
        chk("t2_overrun", 32'(overrun), 1);
        DataValid = 1'b0;
        tick();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t2_commit", 32'(commit), 1);
        chk_disp("t2_disp", 30, 40, 30, 40);
        chk("t2_frame_count", 32'(frame_count), 2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_overrun_clr", 32'(overrun), 0);

        // Out-of-range x2 = 700
        set_coords(5, 700, 5, 6);
        DataValid = 1'b1;
        tick();
        chk("t3_req_ack", 32'(req_ack), 1);
        DataValid = 1'b0;
        tick();
        chk("t3_range_err", 32'(range_err), 0 `ifndef COORD_CLAMP_EN + 1 `endif);
`ifdef COORD_CLAMP_EN
        chk("t3_busy", 32'(busy), 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t3_commit", 32'(commit), 1);
        chk_disp("t3_disp", 5, 639, 5, 6);
`else
        chk("t3_busy", 32'(busy), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t3_commit", 32'(commit), 0);
        chk_disp("t3_disp", 30, 40, 30, 40);
`endif
        chk("t3_frame_count", 32'(frame_count), 3);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_range_err_clr", 32'(range_err), 0);
        chk("t3_idle", 32'(busy), 0);

        // Request coincident with frame_start in PEND
        set_coords(1, 2, 3, 4);
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        tick();
        chk("t4_pend_busy", 32'(busy), 1);
        set_coords(50, 60, 70, 80);
        DataValid   = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t4_commit", 32'(commit), 1);
        chk_disp("t4_disp", 1, 2, 3, 4);
        chk("t4_overrun", 32'(overrun), 1);
        chk("t4_req_ack", 32'(req_ack), 0);
        chk("t4_frame_count", 32'(frame_count), 4);
        // DataValid stays high: no second request
        tick();
        tick();
        tick();
        chk("t4_held_dv_busy", 32'(busy), 0);
        chk("t4_held_dv_ack", 32'(req_ack), 0);
        DataValid = 1'b0;
        tick();

        // frame_count wrap: 4 + 65531 = 0xFFFF, one more -> 0
        frame_start = 1'b1;
        for (int i = 0; i < 65531; i++) begin
            tick();
        end
        chk("t5_frame_count_max", 32'(frame_count), 32'hFFFF);
        tick();
        frame_start = 1'b0;
        chk("t5_frame_count_wrap", 32'(frame_count), 0);
        chk("t5_no_commit", 32'(commit), 0);

        // Reset while pending
        set_coords(7, 8, 9, 10);
        DataValid = 1'b1;
        tick();
        DataValid = 1'b0;
        tick();
        chk("t6_pend_busy", 32'(busy), 1);
        #2 HRESETn = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk_disp("t6_rst_disp", 0, 0, 0, 0);
        chk("t6_rst_overrun", 32'(overrun), 0);
        tick();
        HRESETn = 1'b1;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t6_no_commit", 32'(commit), 0);
        chk_disp("t6_disp_kept", 0, 0, 0, 0);
        chk("t6_frame_count", 32'(frame_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
